// File: rtl/srff_drv_pkg.sv
// Shared definitions for the SR flip-flop excitation driver.
//   - FSM state encoding (legacy-style constants plus a matching enum)
//   - width constants for the state register, the retry counter and the
//     settle down-counter
package srff_drv_pkg;

  localparam int STATE_W = 2;
  localparam int RETRY_W = 3;
  localparam int CNT_W   = 4;

  localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ST_DRIVE  = 2'd1;
  localparam logic [STATE_W-1:0] ST_SETTLE = 2'd2;
  localparam logic [STATE_W-1:0] ST_CHECK  = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = ST_IDLE,
    DRIVE  = ST_DRIVE,
    SETTLE = ST_SETTLE,
    CHECK  = ST_CHECK
  } drv_state_e;

endpackage

// File: rtl/srff_excite_driver_if.sv
// Bus between the excitation driver and its environment.
//   tgt_valid/tgt_ready/tgt_data : target-word handshake
//   S/R                          : per-bit set/reset excitation to the bank
//   Q_fb                         : bank readback
//   done/err/err_sticky          : completion and failure status
//   retry_cnt                    : retries used on the current/last word
// Modports:
//   master : the driver (owns the handshake ready, excitation and status)
//   slave  : the environment (offers targets, owns the bank readback)
interface srff_excite_driver_if
  import srff_drv_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic               tgt_valid;
  logic               tgt_ready;
  logic [WIDTH-1:0]   tgt_data;
  logic [WIDTH-1:0]   S;
  logic [WIDTH-1:0]   R;
  logic [WIDTH-1:0]   Q_fb;
  logic               done;
  logic               err;
  logic               err_sticky;
  logic [RETRY_W-1:0] retry_cnt;

  modport master (
    input  tgt_valid, tgt_data, Q_fb,
    output tgt_ready, S, R, done, err, err_sticky, retry_cnt
  );

  modport slave (
    output tgt_valid, tgt_data, Q_fb,
    input  tgt_ready, S, R, done, err, err_sticky, retry_cnt
  );

endinterface

// File: rtl/srff_excite_enc.sv
// Single-bit SR excitation table: given the wanted value and the current Q,
// produce the set/reset pulse that moves Q to the target.
//   tgt q | s r
//    0  0 | 0 0   already correct
//    0  1 | 0 1   reset
//    1  0 | 1 0   set
//    1  1 | 0 0   already correct
// s and r are never high together.
// Ports: tgt, q (inputs); s, r (outputs).
module srff_excite_enc (
  input  logic tgt,
  input  logic q,
  output logic s,
  output logic r
);

  assign s = tgt & ~q;
  assign r = ~tgt & q;

endmodule

// File: rtl/srff_excite_driver.sv
// Writes a target word into a bank of WIDTH master-slave SR flip-flops.
// A word is taken over a valid/ready handshake, one registered cycle of
// S/R excitation is issued from the target and the bank's Q, S=R=0 is held
// for HOLD_CYC settle cycles, then the readback is compared and the word is
// re-driven up to MAX_RETRY times on mismatch.
//
// Ports:
//   Clk  - clock, all state on the rising edge
//   Rst  - synchronous active-low reset
//   bus  - srff_excite_driver_if.master (handshake, S/R, Q_fb, status)
//
// Build option:
//   SRFF_DRV_CHECK_EN defined   : readback check, retries, err/err_sticky and
//                                 retry_cnt are active.
//   SRFF_DRV_CHECK_EN undefined : the check cycle becomes a pass-through that
//                                 always pulses done (same latency);
//                                 err, err_sticky and retry_cnt read 0.
module srff_excite_driver
  import srff_drv_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int HOLD_CYC  = 1,
  parameter int MAX_RETRY = 3
) (
  input logic                   Clk,
  input logic                   Rst,
  srff_excite_driver_if.master  bus
);

  // Reject parameter values the counters cannot represent.
  if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold_cyc
    $error("srff_excite_driver: HOLD_CYC must be in 1..15");
  end
  if (MAX_RETRY < 0 || MAX_RETRY > 7) begin : g_bad_max_retry
    $error("srff_excite_driver: MAX_RETRY must be in 0..7");
  end

  logic [STATE_W-1:0] state_q, state_d;
  logic [WIDTH-1:0]   tgt_q, tgt_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [CNT_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic               done_q, done_d;
`ifdef SRFF_DRV_CHECK_EN
  logic               err_q, err_d;
  logic               err_sticky_q, err_sticky_d;
  logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
`endif

  // Excitation is computed from the incoming word when a target is accepted
  // (so S/R are already valid in the first DRIVE cycle) and from the latched
  // word when a retry is launched from CHECK.
  logic [WIDTH-1:0] enc_tgt, enc_s, enc_r;

  assign enc_tgt = (state_q == ST_IDLE) ? bus.tgt_data : tgt_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_enc
    srff_excite_enc u_enc (
      .tgt (enc_tgt[i]),
      .q   (bus.Q_fb[i]),
      .s   (enc_s[i]),
      .r   (enc_r[i])
    );
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d      = state_q;
    tgt_d        = tgt_q;
    s_d          = '0;
    r_d          = '0;
    settle_cnt_d = settle_cnt_q;
    done_d       = 1'b0;
`ifdef SRFF_DRV_CHECK_EN
    err_d        = 1'b0;
    err_sticky_d = err_sticky_q;
    retry_cnt_d  = retry_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.tgt_valid) begin
          tgt_d   = bus.tgt_data;
          s_d     = enc_s;
          r_d     = enc_r;
          state_d = ST_DRIVE;
`ifdef SRFF_DRV_CHECK_EN
          retry_cnt_d = '0;
`endif
        end
      end

      ST_DRIVE: begin
        // Count HOLD_CYC cycles down to zero; the zero cycle is the last one.
        settle_cnt_d = CNT_W'(HOLD_CYC - 1);
        state_d      = ST_SETTLE;
      end

      ST_SETTLE: begin
        if (settle_cnt_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          settle_cnt_d = settle_cnt_q - 1'b1;
        end
      end

      ST_CHECK: begin
`ifdef SRFF_DRV_CHECK_EN
        if (bus.Q_fb == tgt_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (retry_cnt_q < RETRY_W'(MAX_RETRY)) begin
          // Re-drive from the bank's present Q, not the original one.
          retry_cnt_d = retry_cnt_q + 1'b1;
          s_d         = enc_s;
          r_d         = enc_r;
          state_d     = ST_DRIVE;
        end else begin
          err_d        = 1'b1;
          err_sticky_d = 1'b1;
          state_d      = ST_IDLE;
        end
`else
        // Pass-through cycle keeps the latency identical to the checked build.
        done_d  = 1'b1;
        state_d = ST_IDLE;
`endif
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: reset is sampled on the clock edge (synchronous), so it sits inside
  // the clocked block rather than in the sensitivity list.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q      <= ST_IDLE;
      tgt_q        <= '0;
      s_q          <= '0;
      r_q          <= '0;
      settle_cnt_q <= '0;
      done_q       <= 1'b0;
`ifdef SRFF_DRV_CHECK_EN
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      retry_cnt_q  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value of the others, regardless of statement order.
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      s_q          <= s_d;
      r_q          <= r_d;
      settle_cnt_q <= settle_cnt_d;
      done_q       <= done_d;
`ifdef SRFF_DRV_CHECK_EN
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
      retry_cnt_q  <= retry_cnt_d;
`endif
    end
  end

  assign bus.tgt_ready = (state_q == ST_IDLE);
  assign bus.S         = s_q;
  assign bus.R         = r_q;
  assign bus.done      = done_q;
`ifdef SRFF_DRV_CHECK_EN
  assign bus.err        = err_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.retry_cnt  = retry_cnt_q;
`else
  assign bus.err        = 1'b0;
  assign bus.err_sticky = 1'b0;
  assign bus.retry_cnt  = '0;
`endif

endmodule
